// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared types and constants for the 1:4 TDM demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Beats per frame
    localparam int SLOTS = 4;

    typedef logic [1:0] slot_t;

    // Frame-alignment FSM: IDLE until the first sync, RUN thereafter
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam slot_t SLOT_I0 = 2'd0;
    localparam slot_t SLOT_I1 = 2'd1;
    localparam slot_t SLOT_I2 = 2'd2;
    localparam slot_t SLOT_I3 = 2'd3;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tdm_slot_cnt
// Purpose  : 2-bit wrapping slot counter. 'restart' means the current beat is
//            slot 0 of a new frame, so the next expected slot is 1.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  adv,
    input  logic  restart,
    output slot_t slot,
    output logic  last
);

    slot_t slot_q;
    slot_t slot_d;

    // Next slot: restart wins over a plain advance; natural 2-bit wrap 3->0
    always_comb begin
        slot_d = slot_q;
        if (restart) begin
            slot_d = SLOT_I1;
        end else if (adv) begin
            slot_d = slot_q + 2'd1;
        end
    end

    // Slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_I0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == SLOT_I3);

endmodule : tdm_slot_cnt
`default_nettype wire

// File: rtl/tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1to4
// Purpose  : Demultiplexes a 4-beat TDM frame stream onto four parallel
//            channels. Slots 0..2 are staged in shadow registers; the slot-3
//            beat goes straight to the output bank so all four channels
//            update together, one cycle after the last beat.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] D,
    input  logic         in_valid,
    input  logic         sync,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic         out_valid,
    output logic [1:0]   S,
    output logic         err
);

    state_t       state_q, state_d;
    logic [W-1:0] shadow_q [SLOTS-1];
    logic [W-1:0] shadow_d [SLOTS-1];
    logic [W-1:0] y_q      [SLOTS];
    logic [W-1:0] y_d      [SLOTS];
    logic         out_valid_q, out_valid_d;
    logic         err_q, err_d;

    logic         cnt_adv;
    logic         cnt_restart;
    slot_t        slot;
    logic         slot_last;

    tdm_slot_cnt u_slot_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (cnt_adv),
        .restart (cnt_restart),
        .slot    (slot),
        .last    (slot_last)
    );

    // Frame FSM: decides what each valid beat does to shadow, outputs and counter
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        cnt_adv     = 1'b0;
        cnt_restart = 1'b0;

        case (state_q)
            IDLE: begin
                // Unsynchronised beats are dropped silently
                if (in_valid && sync) begin
                    shadow_d[0] = D;
                    cnt_restart = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (sync) begin
                        // Sync always realigns; mid-frame it discards the partial frame
                        shadow_d[0] = D;
                        cnt_restart = 1'b1;
                        err_d       = (slot != SLOT_I0);
                    end else begin
                        cnt_adv = 1'b1;
                        case (slot)
                            SLOT_I0: shadow_d[0] = D;
                            SLOT_I1: shadow_d[1] = D;
                            SLOT_I2: shadow_d[2] = D;
                            default: begin
                                // Completing beat bypasses the shadow
                                y_d[0]      = shadow_q[0];
                                y_d[1]      = shadow_q[1];
                                y_d[2]      = shadow_q[2];
                                y_d[3]      = D;
                                out_valid_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < SLOTS - 1; i++) begin
                shadow_q[i] <= '0;
            end
            for (int i = 0; i < SLOTS; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            shadow_q    <= shadow_d;
            y_q         <= y_d;
        end
    end

    assign Y0        = y_q[0];
    assign Y1        = y_q[1];
    assign Y2        = y_q[2];
    assign Y3        = y_q[3];
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign S         = slot;

endmodule : tdm_demux_1to4
`default_nettype wire
